z16_fetch_queue: RTL and testbench



---
 rtl/z16_fetch_queue.sv | 101 ++++++++++
 tb/tb_z16_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_fetch_queue.sv
// Z16 instruction-fetch front end: single-outstanding req/ack fetcher feeding a
// DEPTH-entry PC-tagged instruction queue, with redirect/flush support.
module z16_fetch_queue #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INSTR_W  = 16,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        STEP     = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_imem_req,
  output logic [ADDR_W-1:0]          o_imem_addr,
  input  logic                       i_imem_ack,
  input  logic [INSTR_W-1:0]         i_imem_rdata,
  output logic                       o_valid,
  output logic [INSTR_W-1:0]         o_instr,
  output logic [ADDR_W-1:0]          o_pc,
  input  logic                       i_ready,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_pc,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, count_next;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_next, addr_next;
  logic               req, req_next;
  logic               discard, discard_next;
  logic               ack, push, pop, busy_next;

  always_comb begin
    ack       = req & i_imem_ack;
    push      = ack & ~discard & ~i_redirect;
    pop       = (count != '0) & i_ready & ~i_redirect;
    busy_next = req & ~ack;

    // A redirect with a request still in flight must swallow exactly one response.
    if (i_redirect) begin
      count_next    = '0;
      fetch_pc_next = i_redirect_pc;
      discard_next  = busy_next;
    end else begin
      count_next    = count + CW'(push) - CW'(pop);
      fetch_pc_next = push ? fetch_pc + ADDR_W'(STEP) : fetch_pc;
      discard_next  = discard & ~ack;
    end

    req_next  = req;
    addr_next = o_imem_addr;
    if (!busy_next) begin
      req_next  = (count_next < CW'(DEPTH));
      addr_next = fetch_pc_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      req         <= 1'b0;
      o_imem_addr <= RESET_PC;
      discard     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      req         <= req_next;
      o_imem_addr <= addr_next;
      discard     <= discard_next;
      count       <= count_next;
      rd_ptr      <= i_redirect ? '0 : rd_ptr + PW'(pop);
      wr_ptr      <= i_redirect ? '0 : wr_ptr + PW'(push);
    end
  end

  // Entries are cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[wr_ptr] <= i_imem_rdata;
      q_pc[wr_ptr]    <= o_imem_addr;
    end
  end

  assign o_imem_req = req;
  assign o_valid    = (count != '0);
  assign o_instr    = q_instr[rd_ptr];
  assign o_pc       = q_pc[rd_ptr];
  assign o_count    = count;

endmodule

// File: tb/tb_z16_fetch_queue.sv
// Scoreboard bench for z16_fetch_queue: expected {pc, instr} pushed on each
// accepted fetch, popped and compared on each consumer handshake.
module tb_z16_fetch_queue;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, ack, valid, ready, redirect;
  logic [15:0] addr, rdata, instr, pc, redirect_pc;
  logic [2:0]  count;

  logic        w_rst_n;
  logic        w_req, w_valid;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc;
  logic [2:0]  w_count;

  exp_t        sb[$];
  logic [15:0] exp_fetch;
  logic        discard_m;
  logic        gap_chk;
  int          cyc, last_pop, n_pop;
  int          n_checks, n_errors;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign rdata   = mem_fn(addr);
  assign w_rdata = mem_fn(w_addr);

  z16_fetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000), .STEP(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_valid(valid), .o_instr(instr), .o_pc(pc), .i_ready(ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_count(count)
  );

  z16_fetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFC), .STEP(2)
  ) dut_w (
    .i_clk(clk), .i_rst_n(w_rst_n),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(1'b1), .i_imem_rdata(w_rdata),
    .o_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .i_ready(1'b1),
    .i_redirect(1'b0), .i_redirect_pc(16'h0000), .o_count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Predict this edge's effects from the stable pre-edge inputs/outputs, then advance.
  task automatic step();
    exp_t e;
    if (!redirect && valid && ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("head_pc", pc, e.pc);
        check("head_instr", instr, e.instr);
      end
      if (gap_chk && last_pop >= 0) check("pop_gap", cyc - last_pop, 4);
      last_pop = cyc;
      n_pop++;
    end
    if (req && ack) begin
      if (discard_m) begin
        discard_m = 1'b0;
      end else begin
        check("req_addr", addr, exp_fetch);
        if (!redirect) begin
          sb.push_back('{pc: exp_fetch, instr: mem_fn(exp_fetch)});
          exp_fetch += 16'd2;
        end
      end
    end
    if (redirect) begin
      sb.delete();
      exp_fetch = redirect_pc;
      discard_m = req && !ack;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("count", count, sb.size());
    check("valid", valid, sb.size() != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    sb.delete();
    exp_fetch = 16'h0000;
    discard_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_pop = -1; n_pop = 0; gap_chk = 1'b0;
    w_rst_n = 1'b0;
    #1;
    do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_req", req, 0);
    check("rst_addr", addr, 16'h0000);
    check("rst_valid", valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;

    // Streaming: first edge issues request at RESET_PC, then one instruction per cycle.
    step();
    check("start_req", req, 1);
    check("start_addr", addr, 16'h0000);
    ack = 1'b1; ready = 1'b1;
    step();
    n_pop = 0;
    for (int i = 0; i < 8; i++) step();
    check("stream_pops", n_pop, 8);

    // Backpressure: queue fills to DEPTH, request stops, head holds.
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("bp_count", count, 4);
    check("bp_req", req, 0);
    check("bp_head", pc, 16'h0000);
    ready = 1'b1;
    step();
    check("bp_resume_req", req, 1);
    for (int i = 0; i < 8; i++) step();

    // Wait states: ack three cycles late, address held, one instruction every 4 cycles.
    do_reset();
    ready = 1'b1;
    step();
    gap_chk = 1'b1; last_pop = -1;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] held;
      for (int t = 0; t < 8 && !req; t++) step();
      check("ws_req", req, 1);
      held = addr;
      ack = 1'b0;
      for (int t = 0; t < 3; t++) begin
        step();
        check("ws_addr_hold", addr, held);
        check("ws_req_hold", req, 1);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    step(); step();
    gap_chk = 1'b0;

    // Redirect while a request at 0x0006 is pending.
    do_reset();
    step();
    ack = 1'b1; ready = 1'b1;
    step(); step(); step();
    ack = 1'b0;
    step();
    check("rp_pending_addr", addr, 16'h0006);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    check("rp_count", count, 0);
    step();
    check("rp_old_addr", addr, 16'h0006);
    ack = 1'b1;
    step();
    check("rp_new_req", req, 1);
    check("rp_new_addr", addr, 16'h0100);
    step();
    check("rp_first_pc", pc, 16'h0100);
    for (int i = 0; i < 4; i++) step();

    // Back-to-back redirects while discarding: one response dropped, last PC wins.
    ack = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 16'h0300;
    step();
    redirect_pc = 16'h0380;
    step();
    redirect = 1'b0; ack = 1'b1;
    step();
    check("rr_addr", addr, 16'h0380);
    for (int i = 0; i < 4; i++) step();

    // Redirect coincident with ack and pop at count=2.
    do_reset();
    ack = 1'b1;
    step(); step(); step();
    check("sim_count2", count, 2);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    check("sim_count0", count, 0);
    check("sim_req", req, 1);
    check("sim_addr", addr, 16'h0200);
    step();
    check("sim_no_discard", count, 1);
    for (int i = 0; i < 4; i++) step();

    // Wrap from 0xFFFC, then asynchronous reset mid-burst.
    ack = 1'b0; ready = 1'b0;
    w_rst_n = 1'b1;
    for (int t = 0; t < 6 && !w_valid; t++) step();
    check("wr_valid", w_valid, 1);
    check("wr_pc0", w_pc, 16'hFFFC);
    check("wr_instr0", w_instr, mem_fn(16'hFFFC));
    step();
    check("wr_pc1", w_pc, 16'hFFFE);
    step();
    check("wr_pc2", w_pc, 16'h0000);
    check("wr_instr2", w_instr, mem_fn(16'h0000));
    #3;
    w_rst_n = 1'b0;
    #1;
    check("ar_req", w_req, 0);
    check("ar_addr", w_addr, 16'hFFFC);
    check("ar_valid", w_valid, 0);
    check("ar_instr", w_instr, 0);
    check("ar_pc", w_pc, 0);
    check("ar_count", w_count, 0);
    step();
    check("ar_hold_req", w_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
